// File: rtl/w_gen.sv
// rtl/w_gen.sv - serializes a captured bit field MSB-first with optional gapped repeats
module w_gen #(
    parameter int GAP_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] pattern,
    input  logic [3:0] len,
    input  logic [2:0] reps,
    output logic       w,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

    state_t     state;
    logic [7:0] pat_q;
    logic [2:0] top_q;
    logic [2:0] idx;
    logic [2:0] rep_cnt;
    logic [3:0] gap_cnt;

    logic       len_ok;
    logic [2:0] top_in;
    logic [2:0] idx_next;

    // Request legality, index of the first bit to send, and the next bit index
    always_comb begin
        len_ok   = (len != 4'd0) && (len <= 4'd8);
        top_in   = len[2:0] - 3'd1;
        idx_next = idx - 3'd1;
    end

    // Control FSM; every output is a register updated here
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            pat_q   <= 8'd0;
            top_q   <= 3'd0;
            idx     <= 3'd0;
            rep_cnt <= 3'd0;
            gap_cnt <= 4'd0;
            w       <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    w    <= 1'b0;
                    busy <= 1'b0;
                    if (start) begin
                        if (len_ok) begin
                            pat_q   <= pattern;
                            top_q   <= top_in;
                            idx     <= top_in;
                            rep_cnt <= reps;
                            w       <= pattern[top_in];
                            busy    <= 1'b1;
                            state   <= SHIFT;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    if (idx != 3'd0) begin
                        idx <= idx_next;
                        w   <= pat_q[idx_next];
                    end else if (rep_cnt != 3'd0) begin
                        rep_cnt <= rep_cnt - 3'd1;
                        gap_cnt <= GAP_LAST;
                        w       <= 1'b0;
                        state   <= GAP;
                    end else begin
                        w     <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                GAP: begin
                    if (gap_cnt != 4'd0) begin
                        gap_cnt <= gap_cnt - 4'd1;
                    end else begin
                        idx   <= top_q;
                        w     <= pat_q[top_q];
                        state <= SHIFT;
                    end
                end
                DONE: begin
                    w     <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_w_gen.sv
// tb/tb_w_gen.sv - directed self-checking bench for w_gen
module tb_w_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] pattern;
    logic [3:0] len;
    logic [2:0] reps;
    logic       w;
    logic       busy;
    logic       done;
    logic       err;

    int checks = 0;
    int failures = 0;

    w_gen #(.GAP_CYCLES(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .pattern (pattern),
        .len     (len),
        .reps    (reps),
        .w       (w),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic ew, input logic eb,
                           input logic ed, input logic ee);
        chk({tag, ".w"}, w, ew);
        chk({tag, ".busy"}, busy, eb);
        chk({tag, ".done"}, done, ed);
        chk({tag, ".err"}, err, ee);
    endtask

    // Start a request, then scramble the inputs while busy; exp_w holds n bits MSB-first
    task automatic send(input string tag, input logic [7:0] p, input logic [3:0] l,
                        input logic [2:0] r, input logic [31:0] exp_w, input int n);
        pattern = p;
        len     = l;
        reps    = r;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        pattern = ~p;
        len     = 4'd1;
        reps    = 3'd7;
        for (int k = 0; k < n; k++) begin
            chk_all($sformatf("%s.bit%0d", tag, k), exp_w[n-1-k], 1'b1, 1'b0, 1'b0);
            tick();
        end
        chk_all({tag, ".done"}, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        chk_all({tag, ".idle"}, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; pattern = 8'h00; len = 4'd0; reps = 3'd0;
        tick();
        tick();
        chk_all("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        chk_all("post_reset0", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk_all("post_reset1", 1'b0, 1'b0, 1'b0, 1'b0);

        send("p0d_l4", 8'h0D, 4'd4, 3'd0, 32'b1101, 4);
        send("pf0_l8_r1", 8'hF0, 4'd8, 3'd1, 32'b111100000011110000, 18);
        send("p01_l1_r2", 8'h01, 4'd1, 3'd2, 32'b1001001, 7);

        len = 4'd0; start = 1'b1;
        tick();
        start = 1'b0;
        chk_all("len0_err", 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        chk_all("len0_after", 1'b0, 1'b0, 1'b0, 1'b0);
        len = 4'd9; start = 1'b1;
        tick();
        start = 1'b0;
        chk_all("len9_err", 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        chk_all("len9_after", 1'b0, 1'b0, 1'b0, 1'b0);

        pattern = 8'h05; len = 4'd3; reps = 3'd0; start = 1'b1;
        tick();
        chk_all("restart.bit0", 1'b1, 1'b1, 1'b0, 1'b0);
        pattern = 8'hFF; len = 4'd8; start = 1'b1;
        tick();
        chk_all("restart.bit1", 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        chk_all("restart.bit2", 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        chk_all("restart.done", 1'b0, 1'b0, 1'b1, 1'b0);
        start = 1'b0;
        tick();
        chk_all("restart.idle", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk_all("restart.quiet", 1'b0, 1'b0, 1'b0, 1'b0);

        pattern = 8'hA5; len = 4'd8; reps = 3'd0; start = 1'b1;
        tick();
        start = 1'b0;
        chk_all("abort.bit0", 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        chk_all("abort.bit1", 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        chk_all("abort.bit2", 1'b1, 1'b1, 1'b0, 1'b0);
        rst = 1'b1; start = 1'b1;
        tick();
        chk_all("abort.rst", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk_all("abort.rst_start", 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0; start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk_all($sformatf("abort.quiet%0d", k), 1'b0, 1'b0, 1'b0, 1'b0);
        end

        send("p13_l5", 8'h13, 4'd5, 3'd0, 32'b10011, 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
